osc_dec: RTL and testbench



---
 rtl/osc_dec.sv | 181 ++++++++++++++++++
 tb/tb_osc_dec.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_dec.sv
// osc_dec: decimating / boxcar-averaging stage for the oscilloscope stream.
// Accepts one signed sample per input transfer and emits one sample for every
// N = cfg_dec+1 accepted inputs. The emitted sample is either the last sample
// of the block (plain decimation) or the block sum, arithmetically shifted
// right by cfg_shr and saturated to the output width (average).
// Optional feature macro: OSC_DEC_LAST_EN adds sti_tlast/sto_tlast. With it,
// an input tagged last closes the current (possibly partial) block early.
module osc_dec #(
    parameter int DWI = 16,   // input sample width (signed)
    parameter int DWO = 16,   // output sample width (signed)
    parameter int CW  = 17,   // decimation counter width
    parameter int SHW = 5     // shift-amount width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctl_rst,
    input  logic [CW-1:0]         cfg_dec,
    input  logic                  cfg_avg,
    input  logic [SHW-1:0]        cfg_shr,
    input  logic signed [DWI-1:0] sti_tdata,
    input  logic                  sti_tvalid,
    output logic                  sti_tready,
`ifdef OSC_DEC_LAST_EN
    input  logic                  sti_tlast,
    output logic                  sto_tlast,
`endif
    output logic signed [DWO-1:0] sto_tdata,
    output logic                  sto_tvalid,
    input  logic                  sto_tready
);

    // Accumulator is wide enough to hold 2**CW full-scale samples without
    // overflow, so only the final saturation can clip.
    localparam int AW = DWI + CW;

    localparam logic signed [DWO-1:0] OUT_MAX = {1'b0, {(DWO-1){1'b1}}};
    localparam logic signed [DWO-1:0] OUT_MIN = {1'b1, {(DWO-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_next;
    logic signed [AW-1:0]  acc_reg;
    logic signed [AW-1:0]  acc_next;
    logic signed [DWO-1:0] tdata_reg;
    logic signed [DWO-1:0] tdata_next;
    logic                  tvalid_reg;
    logic                  tvalid_next;
    logic                  tlast_reg;
    logic                  tlast_next;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic in_xfer;
    logic out_xfer;
    logic last_in;
    logic terminal;

    // Single output register: accept input whenever it is empty or draining.
    assign sti_tready = !tvalid_reg || sto_tready;
    assign in_xfer    = sti_tvalid && sti_tready;
    assign out_xfer   = tvalid_reg && sto_tready;

`ifdef OSC_DEC_LAST_EN
    assign last_in   = sti_tlast;
    assign sto_tlast = tlast_reg;
`else
    assign last_in   = 1'b0;
`endif

    // >= rather than == so that lowering cfg_dec mid-block closes the block
    // on the next accepted sample instead of wrapping the counter.
    assign terminal = (cnt_reg >= cfg_dec) || last_in;

    // ------------------------------------------------------------------
    // Datapath: sign extension, sum, shift, selection
    // ------------------------------------------------------------------
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic signed [AW-1:0] sel;
    logic signed [DWO-1:0] sat_data;

    assign x_ext   = {{CW{sti_tdata[DWI-1]}}, sti_tdata};
    assign sum     = acc_reg + x_ext;
    assign shifted = sum >>> cfg_shr;
    assign sel     = cfg_avg ? shifted : x_ext;

    // ------------------------------------------------------------------
    // Saturation of the selected value into the signed output range
    // ------------------------------------------------------------------
    generate
        if (AW >= DWO) begin : g_sat
            // Value fits when every bit from the output sign bit upward
            // agrees with the true sign bit.
            logic [AW-DWO:0] upper;
            logic            sign_diff_any;
            logic [AW-DWO:0] sign_diff;

            assign upper = sel[AW-1:DWO-1];

            for (genvar gi = 0; gi <= AW - DWO; gi++) begin : g_diff
                assign sign_diff[gi] = upper[gi] ^ sel[AW-1];
            end

            assign sign_diff_any = |sign_diff;

            // Clip to the extreme of the true sign when the value overflows.
            always_comb begin
                sat_data = sel[DWO-1:0];
                if (sign_diff_any) begin
                    sat_data = sel[AW-1] ? OUT_MIN : OUT_MAX;
                end
            end
        end else begin : g_ext
            // Output is wider than the accumulator: sign-extend, never clips.
            assign sat_data = {{(DWO-AW){sel[AW-1]}}, sel};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Advance counter/accumulator on each accepted sample and load the
    // output register on a terminal sample; a same-cycle drain and load
    // keeps the output valid with fresh data.
    always_comb begin
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;

        if (out_xfer) begin
            tvalid_next = 1'b0;
        end

        if (in_xfer) begin
            if (terminal) begin
                cnt_next    = '0;
                acc_next    = '0;
                tdata_next  = sat_data;
                tvalid_next = 1'b1;
                tlast_next  = last_in;
            end else begin
                cnt_next    = cnt_reg + CW'(1);
                acc_next    = sum;
            end
        end
    end

    // Register state; hard reset and the soft clear both flush the block
    // and discard any output still waiting for the consumer.
    always_ff @(posedge clk) begin
        if (rst || ctl_rst) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
        end
    end

    assign sto_tdata  = tdata_reg;
    assign sto_tvalid = tvalid_reg;

`ifndef OSC_DEC_LAST_EN
    // tlast state is only observable with the last-tag feature enabled.
    logic unused_tlast;
    assign unused_tlast = tlast_reg;
`endif

endmodule

// File: tb/tb_osc_dec.sv
// Directed testbench for osc_dec. Inputs are driven 1 ns after the rising
// edge; outputs are sampled on the falling edge. Output transfers are
// collected by a monitor and compared against hand-computed expectations.
module tb_osc_dec;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ctl_rst = 1'b0;
    logic [16:0]        cfg_dec = '0;
    logic               cfg_avg = 1'b0;
    logic [4:0]         cfg_shr = '0;
    logic signed [15:0] sti_tdata = '0;
    logic               sti_tvalid = 1'b0;
    logic               sti_tready;
    logic signed [15:0] sto_tdata;
    logic               sto_tvalid;
    logic               sto_tready = 1'b1;
`ifdef OSC_DEC_LAST_EN
    logic               sti_tlast = 1'b0;
    logic               sto_tlast;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int out_q[$];
    int last_q[$];
    int exp_q[$];
    int exp_l_q[$];

    osc_dec dut (
        .clk        (clk),
        .rst        (rst),
        .ctl_rst    (ctl_rst),
        .cfg_dec    (cfg_dec),
        .cfg_avg    (cfg_avg),
        .cfg_shr    (cfg_shr),
        .sti_tdata  (sti_tdata),
        .sti_tvalid (sti_tvalid),
        .sti_tready (sti_tready),
`ifdef OSC_DEC_LAST_EN
        .sti_tlast  (sti_tlast),
        .sto_tlast  (sto_tlast),
`endif
        .sto_tdata  (sto_tdata),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready)
    );

    always #5 clk = ~clk;

    // Record every output transfer that the next rising edge will complete.
    always @(negedge clk) begin
        if (!rst && !ctl_rst && sto_tvalid && sto_tready) begin
            out_q.push_back(int'(sto_tdata));
`ifdef OSC_DEC_LAST_EN
            last_q.push_back(int'(sto_tlast));
            $display("out transfer: data=%0d last=%0d", sto_tdata, sto_tlast);
`else
            $display("out transfer: data=%0d", sto_tdata);
`endif
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input int x);
        bit done = 0;
        sti_tdata  = 16'(x);
        sti_tvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sti_tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        check("send_accept", int'(done), 1);
    endtask

    task automatic idle();
        sti_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        sync();
    endtask

    task automatic compare_outs(input string tag);
        check({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_data%0d", tag, i), out_q[i], exp_q[i]);
`ifdef OSC_DEC_LAST_EN
        for (int i = 0; i < last_q.size() && i < exp_l_q.size(); i++)
            check($sformatf("%s_last%0d", tag, i), last_q[i], exp_l_q[i]);
`endif
        out_q.delete();
        last_q.delete();
        exp_q.delete();
        exp_l_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) sync();
        check("rst_tvalid", int'(sto_tvalid), 0);
        check("rst_tdata", int'(sto_tdata), 0);
        check("rst_tready", int'(sti_tready), 1);
        rst = 1'b0;
        sync();

        // N=1 pass-through, full rate, 1-cycle latency
        cfg_dec = 0; cfg_avg = 0; cfg_shr = 0;
        send(100);
        check("pt_lat0", int'(sto_tvalid), 1);
        check("pt_dat0", int'(sto_tdata), 100);
        check("pt_rdy0", int'(sti_tready), 1);
        send(-5);
        check("pt_dat1", int'(sto_tdata), -5);
        check("pt_rdy1", int'(sti_tready), 1);
        send(32767);
        check("pt_dat2", int'(sto_tdata), 32767);
        idle();
        exp_q = '{100, -5, 32767};
        exp_l_q = '{0, 0, 0};
        compare_outs("passthru");

        // Averaging, N=4, shift 2
        cfg_dec = 3; cfg_avg = 1; cfg_shr = 2;
        send(4); send(8); send(12);
        check("avg_nooutput_midblock", int'(sto_tvalid), 0);
        send(16);
        send(-1); send(-1); send(-1); send(-1);
        idle();
        exp_q = '{10, -1};
        exp_l_q = '{0, 0};
        compare_outs("avg4");

        // Saturation both directions
        cfg_shr = 0;
        repeat (4) send(32767);
        repeat (4) send(-32768);
        idle();
        exp_q = '{32767, -32768};
        exp_l_q = '{0, 0};
        compare_outs("sat");

        // Arithmetic shift of a negative sum rounds toward -inf: -11>>>1 = -6
        cfg_dec = 1; cfg_shr = 1;
        send(-5); send(-6);
        idle();
        exp_q = '{-6};
        exp_l_q = '{0};
        compare_outs("negshift");

        // Plain decimation by 3 emits the last sample of each block
        cfg_dec = 2; cfg_avg = 0;
        send(10); send(20); send(30); send(40); send(50); send(60);
        idle();
        exp_q = '{30, 60};
        exp_l_q = '{0, 0};
        compare_outs("decim3");

        // Mid-block cfg_dec decrease terminates on the next sample
        cfg_dec = 3; cfg_avg = 1; cfg_shr = 0;
        send(5); send(6);
        cfg_dec = 1;
        send(7);
        send(1); send(2);
        idle();
        exp_q = '{18, 3};
        exp_l_q = '{0, 0};
        compare_outs("decshrink");

        // Backpressure: output held, input stalled, nothing lost
        cfg_dec = 0; cfg_avg = 0;
        sto_tready = 1'b0;
        sti_tdata = 1; sti_tvalid = 1'b1;
        sync();
        sti_tdata = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_rdy%0d", i), int'(sti_tready), 0);
            check($sformatf("bp_hold%0d", i), int'(sto_tdata), 1);
        end
        sync();
        sto_tready = 1'b1;
        for (int v = 2; v <= 6; v++) send(v);
        idle();
        exp_q = '{1, 2, 3, 4, 5, 6};
        exp_l_q = '{0, 0, 0, 0, 0, 0};
        compare_outs("backpressure");

        // Soft clear discards a pending output
        sto_tready = 1'b0;
        send(7);
        sti_tvalid = 1'b0;
        ctl_rst = 1'b1;
        sync();
        ctl_rst = 1'b0;
        check("ctlrst_drop_tvalid", int'(sto_tvalid), 0);
        check("ctlrst_drop_tdata", int'(sto_tdata), 0);
        sto_tready = 1'b1;
        sync();

        // Soft clear mid-block discards the partial sum
        cfg_dec = 3; cfg_avg = 1; cfg_shr = 2;
        send(50); send(50);
        sti_tvalid = 1'b0;
        ctl_rst = 1'b1;
        sync();
        ctl_rst = 1'b0;
        sync();
        repeat (4) send(1);
        idle();
        exp_q = '{1};
        exp_l_q = '{0};
        compare_outs("ctlrst_block");

`ifdef OSC_DEC_LAST_EN
        // Forced termination by tlast, then a full block from cnt=0
        cfg_dec = 7; cfg_avg = 1; cfg_shr = 0;
        send(3); send(3);
        sti_tlast = 1'b1;
        send(3);
        sti_tlast = 1'b0;
        repeat (8) send(1);
        idle();
        exp_q = '{9, 8};
        exp_l_q = '{1, 0};
        compare_outs("tlast");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
